// File: rtl/fcw_glide_ctrl_if.sv
// Request channel for fcw_glide_ctrl: target FCW, ramp step and valid/ready handshake.
interface fcw_glide_ctrl_if;
    localparam int unsigned FCW_W = 24;

    logic [FCW_W-1:0] tgt_fcw;
    logic [FCW_W-1:0] tgt_step;
    logic             tgt_valid;
    logic             tgt_ready;

    modport master (output tgt_fcw, output tgt_step, output tgt_valid, input tgt_ready);
    modport slave  (input tgt_fcw, input tgt_step, input tgt_valid, output tgt_ready);
endinterface

// File: rtl/fcw_glide_ctrl.sv
// FCW glide controller: steps fcw toward a requested target once every TICK_DIV cycles.
// Define FCW_GLIDE_EN to enable ramping; without it every request jumps fcw immediately.
module fcw_glide_ctrl #(
    parameter int unsigned TICK_DIV = 1000,
    parameter logic [23:0] INIT_FCW = 24'd0
) (
    input  logic                clk,
    input  logic                reset,
    fcw_glide_ctrl_if.slave     req,
    output logic [23:0]         fcw,
    output logic                busy,
    output logic                settled
);
    localparam int unsigned FCW_W = 24;

    logic ready_q;
    logic accept;

    assign req.tgt_ready = ready_q;
    assign accept        = req.tgt_valid && ready_q;

`ifdef FCW_GLIDE_EN
    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {IDLE, RAMP, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   tick_cnt;
    logic [FCW_W-1:0]   tgt_q;
    logic [FCW_W-1:0]   step_q;
    logic               tick;
    logic               tgt_above;
    logic [FCW_W:0]     dist;

    // Distance to target at 25 bits so the final step can be clamped without wrap.
    assign tick      = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign tgt_above = (tgt_q > fcw);
    assign dist      = tgt_above ? ({1'b0, tgt_q} - {1'b0, fcw})
                                 : ({1'b0, fcw} - {1'b0, tgt_q});

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            fcw      <= INIT_FCW;
            tgt_q    <= INIT_FCW;
            step_q   <= '0;
            tick_cnt <= '0;
            ready_q  <= 1'b0;
            busy     <= 1'b0;
            settled  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    {busy, settled, ready_q} <= 3'b001;
                    if (accept) begin
                        tgt_q    <= req.tgt_fcw;
                        step_q   <= req.tgt_step;
                        tick_cnt <= '0;
                        if ((req.tgt_fcw == fcw) || (req.tgt_step == '0)) begin
                            fcw                      <= req.tgt_fcw;
                            state                    <= DONE;
                            {busy, settled, ready_q} <= 3'b010;
                        end else begin
                            state                    <= RAMP;
                            {busy, settled, ready_q} <= 3'b101;
                        end
                    end
                end
                RAMP: begin
                    tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
                    if (tick) begin
                        if (dist <= {1'b0, step_q}) begin
                            fcw                      <= tgt_q;
                            state                    <= DONE;
                            {busy, settled, ready_q} <= 3'b010;
                        end else if (tgt_above) begin
                            fcw <= fcw + step_q;
                        end else begin
                            fcw <= fcw - step_q;
                        end
                    end
                    // Retarget keeps the tick phase; a zero step jumps and wins over a same-edge tick.
                    if (accept) begin
                        tgt_q  <= req.tgt_fcw;
                        step_q <= req.tgt_step;
                        if (req.tgt_step == '0) begin
                            fcw                      <= req.tgt_fcw;
                            state                    <= DONE;
                            {busy, settled, ready_q} <= 3'b010;
                        end
                    end
                end
                DONE: begin
                    state                    <= IDLE;
                    {busy, settled, ready_q} <= 3'b001;
                end
                default: begin
                    state                    <= IDLE;
                    {busy, settled, ready_q} <= 3'b001;
                end
            endcase
        end
    end
`else
    localparam int unsigned unused_tick_div = TICK_DIV;

    typedef enum logic {IDLE, DONE} state_t;

    state_t state;
    logic   unused_step;

    assign unused_step = ^req.tgt_step;
    assign busy        = 1'b0;

    // Without gliding every accepted request is an immediate jump.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            fcw     <= INIT_FCW;
            ready_q <= 1'b0;
            settled <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    {settled, ready_q} <= 2'b01;
                    if (accept) begin
                        fcw                <= req.tgt_fcw;
                        state              <= DONE;
                        {settled, ready_q} <= 2'b10;
                    end
                end
                DONE: begin
                    state              <= IDLE;
                    {settled, ready_q} <= 2'b01;
                end
                default: begin
                    state              <= IDLE;
                    {settled, ready_q} <= 2'b01;
                end
            endcase
        end
    end
`endif
endmodule

// File: doc/fcw_glide_ctrl.md
FCW_GLIDE_CTRL -- requirements
Module: fcw_glide_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000, clk cycles between successive ramp updates; legal range 2..65535.
REQ-002 Parameter INIT_FCW, default 24'd0, FCW value loaded by reset.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 tgt_fcw  input  24  requested target frequency control word (unsigned).
REQ-006 tgt_step  input  24  per-tick ramp increment magnitude (unsigned), sampled with tgt_fcw.
REQ-007 tgt_valid  input  1  request qualifier for tgt_fcw/tgt_step.
REQ-008 tgt_ready  output  1  controller can accept a request this cycle.
REQ-009 fcw  output  24  registered FCW driven to the phase-accumulator oscillator.
REQ-010 busy  output  1  high while a ramp is in progress (state RAMP).
REQ-011 settled  output  1  one-cycle pulse when fcw reaches the latched target.

Function
REQ-012 Accept SHALL occur on any edge with tgt_valid=1 and tgt_ready=1; tgt_fcw and tgt_step latched into tgt_q and step_q on that edge.
REQ-013 States SHALL be IDLE, RAMP, DONE; tgt_ready=1 in IDLE and RAMP, 0 in DONE.
REQ-014 IDLE: on accept, if tgt_fcw==fcw or tgt_step==0 then fcw<=tgt_fcw and next state DONE; else next state RAMP, tick counter cleared to 0.
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 only in RAMP; tick asserted when count==TICK_DIV-1, counter then wraps to 0; first update occurs TICK_DIV cycles after accept.
REQ-016 On tick: if |tgt_q-fcw| <= step_q then fcw<=tgt_q and next state DONE; else fcw<=fcw+step_q when tgt_q>fcw, fcw<=fcw-step_q when tgt_q<fcw.
REQ-017 Difference SHALL be computed at 25 bits; fcw SHALL never overshoot tgt_q, wrap past 24'hFFFFFF, or underflow below 0.
REQ-018 Retarget in RAMP: new values latched; counter NOT restarted; a tick on the same edge uses the previous tgt_q/step_q.
REQ-019 Retarget in RAMP with tgt_step==0: fcw<=tgt_fcw on that edge, next state DONE (overrides any same-edge tick).
REQ-020 DONE SHALL last exactly one cycle with settled=1, then return to IDLE; requests held through DONE are accepted in IDLE next cycle.
REQ-021 busy SHALL equal (state==RAMP); settled SHALL equal (state==DONE); both registered-state decodes, no combinational path from inputs.
REQ-022 fcw SHALL change only on accept-with-jump, tick, or reset; otherwise holds.

Reset
REQ-023 While reset=0: state IDLE, fcw=INIT_FCW, tgt_q=INIT_FCW, step_q=0, counter=0, busy=0, settled=0, tgt_ready=0.
REQ-024 tgt_ready SHALL rise on the first clk edge after reset returns high.
REQ-025 Reset asserted mid-ramp SHALL abandon the ramp; fcw returns to INIT_FCW on that edge, no settled pulse.

Configuration
REQ-026 Macro FCW_GLIDE_EN: when defined, ramp behaviour of REQ-014..REQ-019 applies.
REQ-027 When FCW_GLIDE_EN undefined: tick counter and RAMP state omitted, tgt_step ignored, every accept sets fcw<=tgt_fcw and enters DONE; busy tied 0.

Verification (TICK_DIV=4, INIT_FCW=0, FCW_GLIDE_EN defined unless noted)
REQ-028 Reset release -> fcw=0, busy=0, settled=0; tgt_ready=1 one cycle after release.
REQ-029 Accept tgt=100, step=30 -> fcw 30,60,90,100 at 4-cycle intervals; settled one cycle after fcw=100; busy low thereafter.
REQ-030 From fcw=100, accept tgt=10, step=50 -> fcw 50 then 10; no value below 10.
REQ-031 Ramp to 1000 step=100, retarget tgt=150 step=20 after fcw=200 -> fcw 180,160,150; single settled pulse.
REQ-032 Accept tgt=24'hFFFFF0 step=24'h800000 from 0 -> fcw 800000 then FFFFF0, no wrap; then tgt=500 step=0 -> fcw=500 next cycle, settled next.
REQ-033 Reset low during ramp at fcw=60 -> fcw=0, busy=0, no settled; FCW_GLIDE_EN undefined build: accept tgt=100 step=30 -> fcw=100 next cycle, busy never high.
